// File: rtl/xaps_api_router.sv
// XAPS API request/response engine: validates a call, routes it onto XR-BUS and
// matches the reply by sequence number. Define XAPS_API_TIMEOUT_EN for the WAIT timeout (504).
module xaps_api_router #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SRC_ID         = 8'hA0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4095:0]        xrbus_frame,
  input  logic                 frame_valid,
  output logic [4095:0]        xrbus_response,
  output logic                 response_valid,
  input  logic [31:0]          api_endpoint,
  input  logic [7:0]           api_method,
  input  logic [1023:0]        api_payload,
  input  logic                 api_request,
  output logic [31:0]          api_status,
  output logic [1023:0]        api_response,
  output logic                 api_response_valid,
  input  logic [255:0][7:0]    route_table
);

  localparam int unsigned FRAME_W   = 4096;
  localparam int unsigned PAYLOAD_W = 1024;
  localparam logic [31:0] TYPE_REQ      = 32'h0000_0A01;
  localparam logic [31:0] TYPE_RSP      = 32'h0000_0A02;
  localparam logic [31:0] ST_OK         = 32'd200;
  localparam logic [31:0] ST_NOT_FOUND  = 32'd404;
  localparam logic [31:0] ST_BAD_METHOD = 32'd405;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             seq_q, seq_d;
  logic [FRAME_W-1:0]     frame_d;
  logic                   frame_vld_d;
  logic [31:0]            status_d;
  logic [PAYLOAD_W-1:0]   resp_d;
  logic                   done_d;

  logic [7:0]             dest_c;
  logic                   method_ok_c;
  logic                   frame_match_c;

  assign dest_c        = route_table[api_endpoint[31:24]];
  assign method_ok_c   = (api_method >= 8'h01) && (api_method <= 8'h04);
  assign frame_match_c = frame_valid && (xrbus_frame[95:64] == TYPE_RSP)
                         && (xrbus_frame[31:24] == seq_q);

  // Only type, seq and payload of an incoming frame matter here.
  logic unused_frame;
  assign unused_frame = ^{xrbus_frame[FRAME_W-1:1120], xrbus_frame[63:32], xrbus_frame[23:0]};

`ifdef XAPS_API_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [31:0] ST_TIMEOUT = 32'd504;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;

  // Fires on the last of TIMEOUT_CYCLES cycles spent in WAIT.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state, request frame and completion decode.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    frame_d     = '0;
    frame_vld_d = 1'b0;
    status_d    = api_status;
    resp_d      = api_response;
    done_d      = 1'b0;
`ifdef XAPS_API_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (api_request) begin
          if (!method_ok_c) begin
            status_d = ST_BAD_METHOD;
            resp_d   = '0;
            done_d   = 1'b1;
          end else if (dest_c == 8'h00) begin
            status_d = ST_NOT_FOUND;
            resp_d   = '0;
            done_d   = 1'b1;
          end else begin
            frame_d[7:0]     = dest_c;
            frame_d[15:8]    = SRC_ID;
            frame_d[23:16]   = api_method;
            frame_d[31:24]   = seq_q;
            frame_d[63:32]   = api_endpoint;
            frame_d[95:64]   = TYPE_REQ;
            frame_d[1119:96] = api_payload;
            frame_vld_d      = 1'b1;
            state_d          = ISSUE;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT;
`ifdef XAPS_API_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT: begin
        // A matching frame beats a timeout landing in the same cycle.
        if (frame_match_c) begin
          status_d = ST_OK;
          resp_d   = xrbus_frame[1119:96];
          done_d   = 1'b1;
          seq_d    = seq_q + 8'd1;
          state_d  = IDLE;
        end
`ifdef XAPS_API_TIMEOUT_EN
        else if (timeout_c) begin
          status_d = ST_TIMEOUT;
          resp_d   = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      seq_q              <= '0;
      xrbus_response     <= '0;
      response_valid     <= 1'b0;
      api_status         <= '0;
      api_response       <= '0;
      api_response_valid <= 1'b0;
    end else begin
      state_q            <= state_d;
      seq_q              <= seq_d;
      xrbus_response     <= frame_d;
      response_valid     <= frame_vld_d;
      api_status         <= status_d;
      api_response       <= resp_d;
      api_response_valid <= done_d;
    end
  end

endmodule

// File: tb/tb_xaps_api_router.sv
// Scoreboard bench for xaps_api_router: random API traffic against a transaction-level model.
module tb_xaps_api_router;

  localparam int unsigned TO  = 8;
  localparam logic [7:0]  SRC = 8'hA0;

  logic               clk = 1'b0;
  logic               rst;
  logic [4095:0]      xrbus_frame;
  logic               frame_valid;
  logic [4095:0]      xrbus_response;
  logic               response_valid;
  logic [31:0]        api_endpoint;
  logic [7:0]         api_method;
  logic [1023:0]      api_payload;
  logic               api_request;
  logic [31:0]        api_status;
  logic [1023:0]      api_response;
  logic               api_response_valid;
  logic [255:0][7:0]  route_table;

  xaps_api_router #(.TIMEOUT_CYCLES(TO), .SRC_ID(SRC)) dut (
    .clk(clk), .rst(rst),
    .xrbus_frame(xrbus_frame), .frame_valid(frame_valid),
    .xrbus_response(xrbus_response), .response_valid(response_valid),
    .api_endpoint(api_endpoint), .api_method(api_method),
    .api_payload(api_payload), .api_request(api_request),
    .api_status(api_status), .api_response(api_response),
    .api_response_valid(api_response_valid),
    .route_table(route_table)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4095:0] data; } exp_frame_t;
  typedef struct { int cyc; logic [31:0] status; logic [1023:0] resp; } exp_done_t;

  exp_frame_t exp_frames[$];
  exp_done_t  exp_dones[$];
  int checks = 0;
  int errors = 0;
  logic [7:0]    model_seq = 8'h00;
  logic [31:0]   last_status = '0;
  logic [1023:0] last_resp = '0;

  function automatic logic [1023:0] rand_pl();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [4095:0] rand_frame();
    logic [4095:0] v;
    for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [4095:0] req_frame(input logic [7:0] dest, input logic [7:0] m,
                                              input logic [7:0] s, input logic [31:0] ep,
                                              input logic [1023:0] pl);
    logic [4095:0] f = '0;
    f[7:0] = dest; f[15:8] = SRC; f[23:16] = m; f[31:24] = s;
    f[63:32] = ep; f[95:64] = 32'h0000_0A01; f[1119:96] = pl;
    return f;
  endfunction

  function automatic logic [4095:0] rsp_frame(input logic [31:0] typ, input logic [7:0] s,
                                              input logic [1023:0] pl);
    logic [4095:0] f = rand_frame();
    f[95:64] = typ; f[31:24] = s; f[1119:96] = pl;
    return f;
  endfunction

  // Monitor: every emitted frame / completion must match the queue head in content and cycle.
  exp_frame_t ef;
  exp_done_t  ed;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (response_valid) begin
        if (exp_frames.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame cyc=%0d got=%h", cyc, xrbus_response[127:0]);
        end else begin
          ef = exp_frames.pop_front();
          if (ef.cyc != cyc || xrbus_response != ef.data) begin
            errors++;
            $display("FAIL req_frame cyc=%0d want_cyc=%0d got=%h want=%h",
                     cyc, ef.cyc, xrbus_response[127:0], ef.data[127:0]);
          end
        end
      end else if (xrbus_response != '0) begin
        errors++;
        $display("FAIL frame_zero_when_idle cyc=%0d got=%h want=0", cyc, xrbus_response[127:0]);
      end
      checks++;
      if (api_response_valid) begin
        if (exp_dones.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion cyc=%0d status=%0d", cyc, api_status);
        end else begin
          ed = exp_dones.pop_front();
          if (ed.cyc != cyc || api_status != ed.status || api_response != ed.resp) begin
            errors++;
            $display("FAIL completion cyc=%0d want_cyc=%0d status=%0d want=%0d resp=%h want=%h",
                     cyc, ed.cyc, api_status, ed.status, api_response[63:0], ed.resp[63:0]);
          end
        end
        last_status = api_status;
        last_resp   = api_response;
      end else if (api_status != last_status || api_response != last_resp) begin
        errors++;
        $display("FAIL status_hold cyc=%0d status=%0d want=%0d resp=%h want=%h",
                 cyc, api_status, last_status, api_response[63:0], last_resp[63:0]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    api_request = 1'b0;
    frame_valid = 1'b0;
    xrbus_frame = '0;
  endtask

  // Drive one request in the current cycle and predict its outcome.
  task automatic do_request(input logic [31:0] ep, input logic [7:0] m,
                            input logic [1023:0] pl, output bit issued);
    logic [7:0] dest;
    exp_frame_t f;
    exp_done_t  d;
    api_endpoint = ep; api_method = m; api_payload = pl; api_request = 1'b1;
    dest   = route_table[ep[31:24]];
    issued = 1'b0;
    if (m < 8'h01 || m > 8'h04) begin
      d.cyc = cyc + 1; d.status = 32'd405; d.resp = '0; exp_dones.push_back(d);
    end else if (dest == 8'h00) begin
      d.cyc = cyc + 1; d.status = 32'd404; d.resp = '0; exp_dones.push_back(d);
    end else begin
      f.cyc = cyc + 1; f.data = req_frame(dest, m, model_seq, ep, pl); exp_frames.push_back(f);
      issued = 1'b1;
    end
  endtask

  // ISSUE cycle, optional distractions in WAIT, then the matching reply (left driven).
  task automatic complete(input int noise, input bit issue_hit, input logic [1023:0] pl);
    exp_done_t d;
    int r;
    step();
    if (issue_hit) begin
      xrbus_frame = rsp_frame(32'h0000_0A02, model_seq, rand_pl()); frame_valid = 1'b1;
      api_request = 1'b1;
    end
    for (int i = 0; i < noise; i++) begin
      step();
      r = $urandom_range(0, 3);
      if (r == 0) begin
        xrbus_frame = rsp_frame(32'h0000_0A02, model_seq + 8'($urandom_range(1, 255)), rand_pl());
        frame_valid = 1'b1;
      end else if (r == 1) begin
        xrbus_frame = rsp_frame(32'h0000_0A01 + 32'($urandom_range(0, 1) * 2), model_seq, rand_pl());
        frame_valid = 1'b1;
      end else if (r == 2) begin
        api_endpoint = 32'h0100_0000 | 32'($urandom_range(0, 65535));
        api_method = 8'h01; api_payload = rand_pl(); api_request = 1'b1;
      end
    end
    step();
    xrbus_frame = rsp_frame(32'h0000_0A02, model_seq, pl); frame_valid = 1'b1;
    d.cyc = cyc + 1; d.status = 32'd200; d.resp = pl; exp_dones.push_back(d);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (response_valid || api_response_valid || xrbus_response != '0 ||
        api_status != '0 || api_response != '0) begin
      errors++;
      $display("FAIL %s rv=%0b arv=%0b status=%0d resp=%h frame=%h want_all_zero", tag,
               response_valid, api_response_valid, api_status, api_response[63:0],
               xrbus_response[127:0]);
    end
  endtask

  function automatic logic [31:0] routed_ep();
    logic [7:0] s;
    do s = 8'($urandom_range(0, 255)); while (route_table[s] == 8'h00);
    return {s, 24'($urandom())};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit issued;
    int n;
    int done200;
    exp_done_t d;
    logic [7:0] m;
    rst = 1'b1; api_request = 1'b0; frame_valid = 1'b0; xrbus_frame = '0;
    api_endpoint = '0; api_method = '0; api_payload = '0;
    for (int i = 0; i < 256; i++)
      route_table[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    route_table[1] = 8'h01;
    route_table[9] = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Directed: routed POST, its reply, bad method, unrouted service.
    step(); do_request(32'h0100_0010, 8'h02, 1024'h55, issued);
    complete(0, 1'b0, 1024'hAB);
    step(); do_request(32'h0100_0020, 8'h07, rand_pl(), issued);
    step(); do_request(32'h0900_0001, 8'h01, rand_pl(), issued);
    step(); do_request(32'h0100_0030, 8'h03, rand_pl(), issued);
    complete(4, 1'b1, rand_pl());

    // Random traffic long enough to wrap the sequence number.
    n = 0; done200 = 0;
    while ((n < 80 || done200 < 270) && n < 2000) begin
      step();
      if ($urandom_range(0, 9) == 0) begin
        xrbus_frame = rsp_frame(32'h0000_0A02, model_seq, rand_pl()); frame_valid = 1'b1;
      end else begin
        if ($urandom_range(0, 6) == 0)
          m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
        else
          m = 8'($urandom_range(1, 4));
        do_request(($urandom_range(0, 3) == 0) ? {8'($urandom_range(0, 255)), 24'($urandom())}
                                               : routed_ep(), m, rand_pl(), issued);
        if (issued) begin
          complete($urandom_range(0, 5), 1'($urandom_range(0, 1)), rand_pl());
          done200++;
        end
      end
      n++;
    end

`ifdef XAPS_API_TIMEOUT_EN
    // No reply: 504 after TO cycles in WAIT.
    step(); do_request(routed_ep(), 8'h01, rand_pl(), issued);
    d.cyc = cyc + 2 + TO; d.status = 32'd504; d.resp = '0; exp_dones.push_back(d);
    repeat (TO + 1) step();
    // Reply on the last WAIT cycle wins over the timeout.
    step(); do_request(routed_ep(), 8'h04, rand_pl(), issued);
    repeat (TO + 1) step();
    xrbus_frame = rsp_frame(32'h0000_0A02, model_seq, 1024'hC0FFEE); frame_valid = 1'b1;
    d.cyc = cyc + 1; d.status = 32'd200; d.resp = 1024'hC0FFEE; exp_dones.push_back(d);
    model_seq = model_seq + 8'd1;
`endif

    // Reset in WAIT aborts silently and restarts seq at 0.
    step(); do_request(routed_ep(), 8'h02, rand_pl(), issued);
    repeat (4) step();
    rst = 1'b1;
    model_seq = 8'h00; last_status = '0; last_resp = '0;
    step(); check_zero("reset_mid_wait");
    repeat (3) step();
    check_zero("reset_hold");
    rst = 1'b0;
    step(); do_request(routed_ep(), 8'h01, rand_pl(), issued);
    complete(1, 1'b0, rand_pl());
    repeat (4) step();

    checks++;
    if (exp_frames.size() != 0 || exp_dones.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations frames=%0d completions=%0d want=0",
               exp_frames.size(), exp_dones.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
